// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm
// Multi-cycle control unit for the 8-bit accumulator CPU. It sequences
// fetch/decode/execute and drives the PC, IR, accumulator, ALU-select and
// data-memory strobes from the 4-bit opcode and the accumulator zero flag.
//
// Optional feature macro: CTRL_MEM_READY_EN
//   undefined : MEM_RD holds for MEM_RD_CYCLES cycles, MEM_WR lasts one cycle
//   defined   : adds input mem_ready; MEM_RD / MEM_WR wait for mem_ready = 1
//
// Parameters:
//   MEM_RD_CYCLES  cycles mReadFlag is held for LDA (1..15)
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   opcode      in   IR[7:4], valid from DECODE onward
//   acc_zero    in   accumulator == 0
//   mem_ready   in   data memory handshake (CTRL_MEM_READY_EN only)
//   ir_ld       out  load instruction register
//   pc_inc      out  PC <= PC + 1
//   pc_ld       out  PC <= target selected by pc_src
//   pc_src      out  0 = PC+1, 1 = IR operand
//   jmp_uncond  out  executing JMP
//   ac_src      out  0 = ALU result, 1 = memory / immediate
//   ld_ac       out  accumulator write enable
//   alu_op      out  latched opcode in EXEC, else 0
//   mReadFlag   out  data-memory read strobe
//   mWriteFlag  out  data-memory write strobe
//   halted      out  in HALT
//   state_dbg   out  current state encoding
//
// state  | meaning
// -------+-----------------------------------------------
// FETCH  | load IR from instruction memory
// DECODE | latch opcode, choose execution path
// EXEC   | ALU / immediate / NOP / jump, one cycle
// MEM_RD | LDA read, accumulator loads on the final cycle
// MEM_WR | STA write strobe
// HALT   | stopped until reset
module cpu_ctrl_fsm #(
  parameter int unsigned MEM_RD_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
`ifdef CTRL_MEM_READY_EN
  input  logic       mem_ready,
`endif
  output logic       ir_ld,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       pc_src,
  output logic       jmp_uncond,
  output logic       ac_src,
  output logic       ld_ac,
  output logic [3:0] alu_op,
  output logic       mReadFlag,
  output logic       mWriteFlag,
  output logic       halted,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JNZ = 4'hC;
  localparam logic [3:0] OP_SHL = 4'hD;
  localparam logic [3:0] OP_SHR = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Down-counter is preloaded in DECODE so the terminal count (0) marks the
  // last read cycle.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_RD_CYCLES - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] opcode_q;
  logic [3:0] wait_cnt;
  logic       rd_last;
  logic       wr_done;

`ifdef CTRL_MEM_READY_EN
  assign rd_last = mem_ready;
  assign wr_done = mem_ready;
`else
  assign rd_last = (wait_cnt == 4'd0);
  assign wr_done = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      opcode_q <= 4'h0;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        opcode_q <= opcode;
        if (opcode == OP_LDA) wait_cnt <= CNT_LOAD;
      end else if (state == S_MEM_RD) begin
        if (rd_last || (wait_cnt == 4'd0)) wait_cnt <= 4'd0;
        else                               wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LDA:  state_nxt = S_MEM_RD;
          OP_STA:  state_nxt = S_MEM_WR;
          OP_HLT:  state_nxt = S_HALT;
          default: state_nxt = S_EXEC;
        endcase
      end
      S_EXEC:   state_nxt = S_FETCH;
      S_MEM_RD: state_nxt = rd_last ? S_FETCH : S_MEM_RD;
      S_MEM_WR: state_nxt = wr_done ? S_FETCH : S_MEM_WR;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;  // illegal codes 6/7 recover
    endcase
  end

  always_comb begin
    ir_ld      = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    pc_src     = 1'b0;
    jmp_uncond = 1'b0;
    ac_src     = 1'b0;
    ld_ac      = 1'b0;
    mReadFlag  = 1'b0;
    mWriteFlag = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: ir_ld = 1'b1;
      S_EXEC: begin
        case (opcode_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
            ld_ac  = 1'b1;
            pc_inc = 1'b1;
          end
          OP_LDI: begin
            ld_ac  = 1'b1;
            ac_src = 1'b1;
            pc_inc = 1'b1;
          end
          OP_NOP: pc_inc = 1'b1;
          OP_JMP: begin
            jmp_uncond = 1'b1;
            pc_src     = 1'b1;
            pc_ld      = 1'b1;
          end
          OP_JZ, OP_JNZ: begin
            // JNZ takes the branch on the inverted zero flag
            if (acc_zero ^ (opcode_q == OP_JNZ)) begin
              pc_src = 1'b1;
              pc_ld  = 1'b1;
            end else begin
              pc_inc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_MEM_RD: begin
        mReadFlag = 1'b1;
        if (rd_last) begin
          ld_ac  = 1'b1;
          ac_src = 1'b1;
          pc_inc = 1'b1;
        end
      end
      S_MEM_WR: begin
        mWriteFlag = 1'b1;
        pc_inc     = wr_done;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign alu_op    = (state == S_EXEC) ? opcode_q : 4'h0;
  assign state_dbg = state;

endmodule
